// File: rtl/seq_ctrl_pkg.sv
// Shared encodings for the Y86 SEQ sequencer: states, icodes, status codes.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_PCUPD     = 3'd5,
    S_STOP      = 3'd6
  } state_t;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVL = 4'h2;
  localparam logic [3:0] I_IRMOVL = 4'h3;
  localparam logic [3:0] I_RMMOVL = 4'h4;
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_OPL    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHL  = 4'hA;
  localparam logic [3:0] I_POPL   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  // Instructions that touch data memory.
  function automatic logic needs_mem(input logic [3:0] ic);
    case (ic)
      I_RMMOVL, I_MRMOVL, I_CALL, I_RET, I_PUSHL, I_POPL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Memory instructions that store rather than load.
  function automatic logic mem_write(input logic [3:0] ic);
    case (ic)
      I_RMMOVL, I_CALL, I_PUSHL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Instructions that write the register file (cmov gating lives in the datapath).
  function automatic logic writes_reg(input logic [3:0] ic);
    case (ic)
      I_RRMOVL, I_IRMOVL, I_MRMOVL, I_OPL, I_CALL, I_RET, I_PUSHL, I_POPL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_ctrl_mem_timer.sv
// Wait counter for the imem/dmem handshakes, shared since only one request is live at a time.
// Latency: timeout is combinational in the LIMIT-th consecutive unacked request cycle.
// Backpressure: counts while req is high and ack low; clears whenever idle or acked.
module mem_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_ack,
  output logic o_timeout
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] r_cnt;

  // Count unacked request cycles; saturate at the last value so a disabled limit cannot wrap.
  always_ff @(posedge clk) begin
    if (rst || !i_req || i_ack) begin
      r_cnt <= '0;
    end else if (r_cnt != LAST) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // An ack in the limit cycle wins, so the ack term masks the timeout.
  assign o_timeout = (LIMIT != 0) && i_req && !i_ack && (r_cnt == LAST);

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle Y86 SEQ sequencer: stage enables, imem/dmem handshakes, status and retire count.
// Latency: 5 cycles per non-memory instruction, 6 per memory instruction, +1 per ack wait cycle.
// Backpressure: requests held high until ack; timeout after MEM_TIMEOUT wait cycles raises ADR.
module seq_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  icode_i,
  input  logic        instr_valid_i,
  output logic        imem_req_o,
  input  logic        imem_ack_i,
  input  logic        imem_error_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  input  logic        dmem_ack_i,
  input  logic        dmem_error_i,
  output logic        fetch_en_o,
  output logic        decode_en_o,
  output logic        exec_en_o,
  output logic        cc_en_o,
  output logic        mem_en_o,
  output logic        wb_en_o,
  output logic        pc_en_o,
  output logic [2:0]  stat_o,
  output logic        halted_o,
  output logic [31:0] retired_o
);

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_stat;
  logic [2:0]  w_stat_next;
  logic [3:0]  r_icode;
  logic [31:0] r_retired;
  logic        w_req;
  logic        w_ack;
  logic        w_timeout;

  assign w_req = (r_state == S_FETCH) || (r_state == S_MEMORY);
  assign w_ack = ((r_state == S_FETCH) && imem_ack_i) || ((r_state == S_MEMORY) && dmem_ack_i);

  mem_timer #(.LIMIT(MEM_TIMEOUT)) u_mem_timer (
    .clk       (clk),
    .rst       (rst),
    .i_req     (w_req),
    .i_ack     (w_ack),
    .o_timeout (w_timeout)
  );

  // State and status registers; STOP is only left through reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_stat  <= SAOK;
    end else begin
      r_state <= w_next;
      r_stat  <= w_stat_next;
    end
  end

  // Capture icode at DECODE so later stages do not depend on the decoder holding it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_icode <= I_NOP;
    end else if (r_state == S_DECODE) begin
      r_icode <= icode_i;
    end
  end

  // Retire count advances only on PCUPD, so halted or faulting instructions never count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired <= '0;
    end else if (r_state == S_PCUPD) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  // Next state, status update and stage/request decode; everything is forced low during reset.
  always_comb begin
    w_next      = r_state;
    w_stat_next = r_stat;
    imem_req_o  = 1'b0;
    dmem_req_o  = 1'b0;
    dmem_we_o   = 1'b0;
    fetch_en_o  = 1'b0;
    decode_en_o = 1'b0;
    exec_en_o   = 1'b0;
    cc_en_o     = 1'b0;
    mem_en_o    = 1'b0;
    wb_en_o     = 1'b0;
    pc_en_o     = 1'b0;
    halted_o    = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          if (imem_error_i) begin
            w_stat_next = SADR;
            w_next      = S_STOP;
          end else begin
            fetch_en_o = 1'b1;
            w_next     = S_DECODE;
          end
        end else if (w_timeout) begin
          w_stat_next = SADR;
          w_next      = S_STOP;
        end
      end
      S_DECODE: begin
        decode_en_o = 1'b1;
        if (icode_i == I_HALT) begin
          w_stat_next = SHLT;
          w_next      = S_STOP;
        end else if ((icode_i > I_POPL) || !instr_valid_i) begin
          w_stat_next = SINS;
          w_next      = S_STOP;
        end else begin
          w_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        exec_en_o = 1'b1;
        cc_en_o   = (r_icode == I_OPL);
        w_next    = needs_mem(r_icode) ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = mem_write(r_icode);
        if (dmem_ack_i) begin
          if (dmem_error_i) begin
            w_stat_next = SADR;
            w_next      = S_STOP;
          end else begin
            mem_en_o = 1'b1;
            w_next   = S_WRITEBACK;
          end
        end else if (w_timeout) begin
          w_stat_next = SADR;
          w_next      = S_STOP;
        end
      end
      S_WRITEBACK: begin
        wb_en_o = writes_reg(r_icode);
        w_next  = S_PCUPD;
      end
      S_PCUPD: begin
        pc_en_o = 1'b1;
        w_next  = S_FETCH;
      end
      S_STOP: begin
        halted_o = 1'b1;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
    if (rst) begin
      imem_req_o  = 1'b0;
      dmem_req_o  = 1'b0;
      dmem_we_o   = 1'b0;
      fetch_en_o  = 1'b0;
      decode_en_o = 1'b0;
      exec_en_o   = 1'b0;
      cc_en_o     = 1'b0;
      mem_en_o    = 1'b0;
      wb_en_o     = 1'b0;
      pc_en_o     = 1'b0;
      halted_o    = 1'b0;
    end
  end

  assign stat_o    = r_stat;
  assign retired_o = r_retired;

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl: per-scenario tasks with hand-computed enable/status sequences.
// Inputs change on the falling edge, outputs are sampled 1 ns later.
// A global watchdog ends the run if a scenario ever stalls.
module tb_seq_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  icode;
  logic        valid;
  logic        imem_req, imem_ack, imem_error;
  logic        dmem_req, dmem_we, dmem_ack, dmem_error;
  logic        fetch_en, decode_en, exec_en, cc_en, mem_en, wb_en, pc_en;
  logic [2:0]  stat;
  logic        halted;
  logic [31:0] retired;
  logic [6:0]  en;

  int n_checks = 0;
  int n_errors = 0;

  // en bit weights: fetch 40, decode 20, exec 10, cc 08, mem 04, wb 02, pc 01
  assign en = {fetch_en, decode_en, exec_en, cc_en, mem_en, wb_en, pc_en};

  seq_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .icode_i       (icode),
    .instr_valid_i (valid),
    .imem_req_o    (imem_req),
    .imem_ack_i    (imem_ack),
    .imem_error_i  (imem_error),
    .dmem_req_o    (dmem_req),
    .dmem_we_o     (dmem_we),
    .dmem_ack_i    (dmem_ack),
    .dmem_error_i  (dmem_error),
    .fetch_en_o    (fetch_en),
    .decode_en_o   (decode_en),
    .exec_en_o     (exec_en),
    .cc_en_o       (cc_en),
    .mem_en_o      (mem_en),
    .wb_en_o       (wb_en),
    .pc_en_o       (pc_en),
    .stat_o        (stat),
    .halted_o      (halted),
    .retired_o     (retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input logic ia, input logic ie, input logic da, input logic de);
    @(negedge clk);
    imem_ack = ia; imem_error = ie; dmem_ack = da; dmem_error = de;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; imem_ack = 0; imem_error = 0; dmem_ack = 0; dmem_error = 0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; imem_ack = 1; dmem_ack = 1; icode = 4'h1; valid = 1'b1;
    #1;
    n_checks++;
    if ({en, imem_req, dmem_req, halted} !== 10'b0) begin
      n_errors++; $display("FAIL reset_outputs_low: got %b want 0", {en, imem_req, dmem_req, halted});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    n_checks++;
    if (stat !== 3'd1) begin n_errors++; $display("FAIL reset_stat: got %0d want 1", stat); end
    n_checks++;
    if (retired !== 32'd0) begin n_errors++; $display("FAIL reset_retired: got %0d want 0", retired); end
    do_reset();
    cyc(0, 0, 0, 0);
    n_checks++;
    if ({imem_req, dmem_req, halted, en} !== {3'b100, 7'h00}) begin
      n_errors++; $display("FAIL reset_fetch_idle: got %b want 1000000000", {imem_req, dmem_req, halted, en});
    end
  endtask

  task automatic test_nop();
    logic [6:0] exp_en [0:4];
    exp_en = '{7'h40, 7'h20, 7'h10, 7'h00, 7'h01};
    do_reset();
    icode = 4'h1; valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(i == 0, 0, 0, 0);
      n_checks++;
      if (en !== exp_en[i]) begin n_errors++; $display("FAIL nop_en[%0d]: got %h want %h", i, en, exp_en[i]); end
    end
    n_checks++;
    if (retired !== 32'd0) begin n_errors++; $display("FAIL nop_retired_in_pcupd: got %0d want 0", retired); end
    cyc(0, 0, 0, 0);
    n_checks++;
    if ({retired, stat, imem_req} !== {32'd1, 3'd1, 1'b1}) begin
      n_errors++; $display("FAIL nop_after: got retired=%0d stat=%0d ireq=%b want 1 1 1", retired, stat, imem_req);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_en [0:4];
    exp_en = '{7'h40, 7'h20, 7'h18, 7'h02, 7'h01};
    icode = 4'h6; valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(i == 0, 0, 0, 0);
      n_checks++;
      if (en !== exp_en[i]) begin n_errors++; $display("FAIL opl_en[%0d]: got %h want %h", i, en, exp_en[i]); end
    end
    cyc(0, 0, 0, 0);
    n_checks++;
    if (retired !== 32'd2) begin n_errors++; $display("FAIL opl_retired: got %0d want 2", retired); end
  endtask

  task automatic test_pushl_fault();
    logic [6:0] exp_en [0:2];
    exp_en = '{7'h40, 7'h20, 7'h10};
    icode = 4'hA; valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(i == 0, 0, 0, 0);
      n_checks++;
      if (en !== exp_en[i]) begin n_errors++; $display("FAIL pushl_en[%0d]: got %h want %h", i, en, exp_en[i]); end
    end
    cyc(0, 0, 1, 1);
    n_checks++;
    if ({dmem_req, dmem_we, en, stat} !== {2'b11, 7'h00, 3'd1}) begin
      n_errors++; $display("FAIL pushl_mem_err_cycle: got req=%b we=%b en=%h stat=%0d want 1 1 00 1", dmem_req, dmem_we, en, stat);
    end
    cyc(0, 0, 0, 0);
    n_checks++;
    if ({stat, halted, en, retired} !== {3'd3, 1'b1, 7'h00, 32'd2}) begin
      n_errors++; $display("FAIL pushl_stop: got stat=%0d halted=%b en=%h retired=%0d want 3 1 00 2", stat, halted, en, retired);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1, 0);
      n_checks++;
      if ({en, imem_req, dmem_req, halted, stat} !== {7'h00, 2'b00, 1'b1, 3'd3}) begin
        n_errors++; $display("FAIL stop_ignores_ack[%0d]: got en=%h ireq=%b dreq=%b halted=%b stat=%0d", i, en, imem_req, dmem_req, halted, stat);
      end
    end
  endtask

  task automatic test_decode_faults();
    logic [3:0] ic [0:2];
    logic       vl [0:2];
    logic [2:0] st [0:2];
    ic = '{4'hC, 4'h2, 4'h0};
    vl = '{1'b1, 1'b0, 1'b1};
    st = '{3'd4, 3'd4, 3'd2};
    for (int k = 0; k < 3; k++) begin
      do_reset();
      icode = ic[k]; valid = vl[k];
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      n_checks++;
      if ({en, stat} !== {7'h20, 3'd1}) begin
        n_errors++; $display("FAIL dec_fault_decode[%0d]: got en=%h stat=%0d want 20 1", k, en, stat);
      end
      cyc(0, 0, 0, 0);
      n_checks++;
      if ({en, stat, halted} !== {7'h00, st[k], 1'b1}) begin
        n_errors++; $display("FAIL dec_fault_stop[%0d]: got en=%h stat=%0d halted=%b want 00 %0d 1", k, en, stat, halted, st[k]);
      end
    end
  endtask

  task automatic test_mrmovl_wait();
    logic [7:0] exp [0:8];
    exp = '{8'h40, 8'h20, 8'h10, 8'h80, 8'h80, 8'h80, 8'h84, 8'h02, 8'h01};
    do_reset();
    icode = 4'h5; valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc(i == 0, 0, i == 6, 0);
      n_checks++;
      if ({dmem_req, en} !== exp[i]) begin
        n_errors++; $display("FAIL mrmovl[%0d]: got %h want %h", i, {dmem_req, en}, exp[i]);
      end
      if (dmem_req === 1'b1) begin
        n_checks++;
        if (dmem_we !== 1'b0) begin n_errors++; $display("FAIL mrmovl_we[%0d]: got %b want 0", i, dmem_we); end
      end
    end
    cyc(0, 0, 0, 0);
    n_checks++;
    if (retired !== 32'd1) begin n_errors++; $display("FAIL mrmovl_retired: got %0d want 1", retired); end
  endtask

  task automatic test_timeout();
    do_reset();
    icode = 4'h1; valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0);
      n_checks++;
      if ({imem_req, en, halted} !== {1'b1, 7'h00, 1'b0}) begin
        n_errors++; $display("FAIL timeout_wait[%0d]: got ireq=%b en=%h halted=%b want 1 00 0", i, imem_req, en, halted);
      end
    end
    cyc(0, 0, 0, 0);
    n_checks++;
    if ({halted, stat, imem_req} !== {1'b1, 3'd3, 1'b0}) begin
      n_errors++; $display("FAIL timeout_stop: got halted=%b stat=%0d ireq=%b want 1 3 0", halted, stat, imem_req);
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(i == 3, 0, 0, 0);
    end
    n_checks++;
    if (en !== 7'h40) begin n_errors++; $display("FAIL timeout_ack_wins_fetch: got %h want 40", en); end
    cyc(0, 0, 0, 0);
    n_checks++;
    if ({en, halted, stat} !== {7'h20, 1'b0, 3'd1}) begin
      n_errors++; $display("FAIL timeout_ack_wins_decode: got en=%h halted=%b stat=%0d want 20 0 1", en, halted, stat);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    icode = 4'h8; valid = 1'b1;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    n_checks++;
    if ({dmem_req, dmem_we, en} !== {2'b11, 7'h00}) begin
      n_errors++; $display("FAIL call_mem: got req=%b we=%b en=%h want 1 1 00", dmem_req, dmem_we, en);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({en, imem_req, dmem_req, halted} !== 10'b0) begin
      n_errors++; $display("FAIL midreset_cycle: got %b want 0", {en, imem_req, dmem_req, halted});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(0, 0, 0, 0);
    n_checks++;
    if ({imem_req, dmem_req, en, retired, stat} !== {2'b10, 7'h00, 32'd0, 3'd1}) begin
      n_errors++; $display("FAIL midreset_after: got ireq=%b dreq=%b en=%h retired=%0d stat=%0d want 1 0 00 0 1", imem_req, dmem_req, en, retired, stat);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    icode = 4'h1; valid = 1'b1;
    @(negedge clk);
    force dut.r_retired = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired;
    for (int i = 0; i < 5; i++) begin
      cyc(i == 0, 0, 0, 0);
    end
    n_checks++;
    if ({en, retired} !== {7'h01, 32'hFFFF_FFFF}) begin
      n_errors++; $display("FAIL wrap_pcupd: got en=%h retired=%h want 01 ffffffff", en, retired);
    end
    cyc(0, 0, 0, 0);
    n_checks++;
    if (retired !== 32'd0) begin n_errors++; $display("FAIL wrap_retired: got %h want 0", retired); end
  endtask

  initial begin
    rst = 1'b1; icode = 4'h1; valid = 1'b1;
    imem_ack = 0; imem_error = 0; dmem_ack = 0; dmem_error = 0;
    test_reset();
    test_nop();
    test_back_to_back();
    test_pushl_fault();
    test_decode_faults();
    test_mrmovl_wait();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_ctrl.md
# seq_ctrl

Multi-cycle sequencer for the Y86 SEQ datapath. It walks each instruction through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPD, and pulses the per-stage latch enables. It owns the instruction-memory and data-memory request/acknowledge handshakes, maintains the processor status code, and counts retired instructions. It sits beside the fetch/decode (`id`) block and takes `icode` from it.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 255: maximum cycles a request may wait for ack before an ADR fault is raised; 0 disables the timeout.

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `icode_i`  in  4  icode from decode, valid from the DECODE cycle onward
- `instr_valid_i`  in  1  decode reports a legal icode/ifun pair
- `imem_req_o`  out  1  instruction fetch request
- `imem_ack_i`  in  1  fetch done; instruction bytes valid this cycle
- `imem_error_i`  in  1  fetch address invalid, qualified by ack
- `dmem_req_o`  out  1  data memory request
- `dmem_we_o`  out  1  1 = write, 0 = read; valid while `dmem_req_o`
- `dmem_ack_i`  in  1  data access done
- `dmem_error_i`  in  1  data address invalid, qualified by ack
- `fetch_en_o`, `decode_en_o`, `exec_en_o`, `cc_en_o`, `mem_en_o`, `wb_en_o`, `pc_en_o`  out  1 each  single-cycle stage enables
- `stat_o`  out  3  AOK=1, HLT=2, ADR=3, INS=4
- `halted_o`  out  1  sequencer is stopped
- `retired_o`  out  32  count of completed instructions

## Operation
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, STOP.
- **FETCH**
  - `imem_req_o`=1.
  - On ack with no error: `fetch_en_o`=1, then go to DECODE.
  - On ack with error: stat ADR, go to STOP, no `fetch_en_o`.
- **DECODE** (one cycle), `decode_en_o`=1:
  - icode 0 (HALT): stat HLT, go to STOP.
  - icode > 0xB or `instr_valid_i`=0: stat INS, go to STOP. `decode_en_o` still pulses.
  - Otherwise go to EXECUTE.
- **EXECUTE** (one cycle), `exec_en_o`=1:
  - `cc_en_o`=1 only for OPL (6).
  - Next state is MEMORY for RMMOVL (4), MRMOVL (5), CALL (8), RET (9), PUSHL (A), POPL (B); otherwise WRITEBACK.
- **MEMORY**
  - `dmem_req_o`=1.
  - `dmem_we_o`=1 for 4, 8, A; 0 for 5, 9, B.
  - On ack with no error: `mem_en_o`=1, then go to WRITEBACK.
  - On ack with error: stat ADR, go to STOP, no `mem_en_o`.
- **WRITEBACK** (one cycle)
  - `wb_en_o`=1 for icodes 2, 3, 5, 6, 8, 9, A, B; 0 for 1, 4, 7.
  - CMOVXX condition gating is done in the datapath, not here.
- **PCUPD** (one cycle): `pc_en_o`=1, `retired_o` increments (wraps 0xFFFFFFFF→0), then go to FETCH.
- **STOP**
  - `halted_o`=1; all requests and enables are 0.
  - `stat_o` holds its value.
  - Left only by `rst`.
- **Timeout**
  - A wait counter clears on entry to FETCH or MEMORY and counts cycles with req=1 and ack=0.
  - When it reaches `MEM_TIMEOUT` (nonzero): stat ADR, go to STOP.
  - An ack in the same cycle the limit is reached wins: the access completes normally.
- Ack or error inputs outside FETCH/MEMORY are ignored.
- **Reset:** state FETCH, `stat_o`=AOK (1), `retired_o`=0, `halted_o`=0, all enables and requests 0 during the reset cycle. Reset mid-instruction abandons that instruction; `pc_en_o` is not pulsed.

## Timing
- All outputs are registered-state decodes. Enables are Moore outputs, except `fetch_en_o` and `mem_en_o`, which are asserted in the cycle the ack is seen (req AND ack).
- Minimum latency with same-cycle ack, first FETCH cycle to last PCUPD cycle:
  - 5 cycles for non-memory instructions.
  - 6 cycles for memory instructions.
- Each wait cycle on an ack adds one cycle.
- Requests stay high continuously until ack; no deassertion while waiting.
- `stat_o` and `halted_o` update the cycle after the faulting or HALT cycle, together with entry to STOP.
- `retired_o` updates the cycle after PCUPD. HALT and faulting instructions are not counted.

## Structure
- Add to the shared `defines.v`:
  - icode constants (HALT..POPL) if not already present.
  - stat codes `SAOK`/`SHLT`/`SADR`/`SINS`.
  - state encodings for the seven states.
- One sub-module, `mem_timer`: the wait counter plus the timeout compare, instantiated once and shared by FETCH and MEMORY (only one is active at a time).
- Everything else lives in `seq_ctrl`: state register, next-state logic, icode classification, output decode, retire counter.

## Test plan
- **NOP after reset, acks same cycle:** enables in order fetch, decode, exec, wb=0, pc over 5 cycles. `retired_o` goes 0→1, `stat_o`=1.
- **MRMOVL with dmem ack delayed 3 cycles:** `dmem_req_o` high 4 cycles with `dmem_we_o`=0, `mem_en_o` in the 4th cycle, `wb_en_o`=1, total 9 cycles.
- **Faults:**
  - PUSHL with `dmem_error_i`=1 on ack: `dmem_we_o`=1, then `stat_o`=3, `halted_o`=1, no wb/pc enable, `retired_o` unchanged.
  - icode 0xC: `stat_o`=4 after DECODE.
  - icode 0: `stat_o`=2.
  - Further acks produce no enables.
- **Timeout, `MEM_TIMEOUT`=4, imem never acks:** STOP after 4 request cycles with `stat_o`=3. Repeat with ack arriving on the 4th cycle: the instruction proceeds normally.
- **Reset during MEMORY of CALL:** next cycle state FETCH, `imem_req_o`=1, `dmem_req_o`=0, `retired_o`=0, `stat_o`=1. Also preload `retired_o`=0xFFFFFFFF via a forced run and check the wrap to 0.
